// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, default
// latencies, FSM state type, the pending-result record and the
// behavioural arithmetic that produces it.
package mdu_ctrl_pkg;

  // Opcodes driven by the decoder on mdu_op; any other value is a no-op.
  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  // Default busy latencies in cycles.
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Result waiting to retire; wr is clear for a divide by zero so that
  // HI/LO keep their previous contents.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } mdu_res_t;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic mdu_is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Full 64-bit result of a multiply or divide. Signed operands are
  // sign-extended to 64 bits so that 0x80000000 / -1 yields +2^31, whose
  // low word is 0x80000000 with a zero remainder.
  function automatic mdu_res_t mdu_compute(input logic [3:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    mdu_res_t          res;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    res = '0;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    case (op)
      MDU_MULT: begin
        {res.hi, res.lo} = sa * sb;
        res.wr = 1'b1;
      end
      MDU_MULTU: begin
        {res.hi, res.lo} = {32'd0, a} * {32'd0, b};
        res.wr = 1'b1;
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          res.lo = 32'(sa / sb);
          res.hi = 32'(sa % sb);
          res.wr = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          res.lo = a / b;
          res.hi = a % b;
          res.wr = 1'b1;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with its own HI/LO pair. The result is
// computed when the op is accepted, held in pending registers, and written
// to HI/LO when the busy down-counter retires the operation.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        busy_any,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_BITS < 4) ? 4 : CNT_BITS;

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  mdu_res_t         pend_q;
  mdu_res_t         pend_d;

  // Behavioural multiplier/divider feeding the pending registers.
  always_comb begin
    // NOTE: default first, so every path assigns pend_d and no latch forms.
    pend_d = '0;
    if (mdu_is_muldiv(mdu_op)) begin
      pend_d = mdu_compute(mdu_op, rs_val, rt_val);
    end
  end

  // IDLE/RUN sequencer with busy counter, pending result and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Pending result is cleared too, so an aborted op leaves no trace.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (mdu_op)
              MDU_MULT, MDU_MULTU: begin
                pend_q  <= pend_d;
                cnt_q   <= MULT_LAT;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                pend_q  <= pend_d;
                cnt_q   <= DIV_LAT;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
              end
              MDU_MTHI: hi_q <= rs_val;
              MDU_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // A start arriving here is ignored; the hazard unit holds it.
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (pend_q.wr) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Stall request: in-flight op, or a mult/div being issued this cycle.
  always_comb begin
    busy_any = busy_q | (start & mdu_is_muldiv(mdu_op));
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
